// File: rtl/adc_avg_filter.sv
// Moving-average filter for an ADC whose chip-select strobe is asynchronous to clk.
// Each strobe edge captures one sample; the window average is offered on a valid/ready port.
module adc_avg_filter #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sample_in,
  input  logic        sample_strobe,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_valid,
  output logic        overrun
);

  localparam int WIN   = 1 << DEPTH_LOG2;
  localparam int SUM_W = 16 + DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FILL_FULL = (DEPTH_LOG2 + 1)'(WIN);
  localparam logic [DEPTH_LOG2:0]   FILL_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    ACCUM   = 2'd2,
    PRESENT = 2'd3
  } state_t;

  state_t                  state_r;
  state_t                  state_next_s;
  logic                    sync1_r;
  logic                    sync2_r;
  logic                    sync3_r;
  logic                    edge_s;
  logic                    discard_s;
  logic signed [15:0]      sample_r;
  logic signed [15:0]      oldest_r;
  logic signed [15:0]      buf_r [WIN];
  logic signed [SUM_W-1:0] sum_r;
  logic signed [SUM_W-1:0] sum_next_s;
  logic        [15:0]      avg_s;
  logic [DEPTH_LOG2-1:0]   wr_ptr_r;
  logic [DEPTH_LOG2:0]     fill_r;
  logic [DEPTH_LOG2:0]     fill_next_s;
  logic [15:0]             out_data_r;
  logic                    out_valid_r;
  logic                    overrun_r;

  // two-stage strobe synchronizer plus one delay stage for rising-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      sync3_r <= 1'b0;
    end else begin
      sync1_r <= sample_strobe;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
    end
  end

  assign edge_s = sync2_r & ~sync3_r;

  // running-sum update and saturating fill count for the ACCUM step
  always_comb begin
    sum_next_s  = sum_r + {{DEPTH_LOG2{sample_r[15]}}, sample_r}
                        - {{DEPTH_LOG2{oldest_r[15]}}, oldest_r};
    avg_s       = 16'(sum_next_s >>> DEPTH_LOG2);
    if (fill_r == FILL_FULL) begin
      fill_next_s = fill_r;
    end else begin
      fill_next_s = fill_r + FILL_ONE;
    end
  end

  // next-state logic; an edge that cannot be taken is flagged for overrun
  always_comb begin
    state_next_s = state_r;
    discard_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (edge_s) begin
          state_next_s = CAPTURE;
        end else begin
          state_next_s = IDLE;
        end
      end
      CAPTURE: begin
        state_next_s = ACCUM;
        discard_s    = edge_s;
      end
      ACCUM: begin
        discard_s = edge_s;
        if (fill_next_s == FILL_FULL) begin
          state_next_s = PRESENT;
        end else begin
          state_next_s = IDLE;
        end
      end
      PRESENT: begin
        if (out_ready) begin
          if (edge_s) begin
            state_next_s = CAPTURE;
          end else begin
            state_next_s = IDLE;
          end
        end else begin
          state_next_s = PRESENT;
          discard_s    = edge_s;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // sample capture, window buffer and running sum
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_r <= 16'sd0;
      oldest_r <= 16'sd0;
      sum_r    <= '0;
      wr_ptr_r <= '0;
      fill_r   <= '0;
      for (int i = 0; i < WIN; i++) begin
        buf_r[i] <= 16'sd0;
      end
    end else begin
      case (state_r)
        CAPTURE: begin
          sample_r <= sample_in;
          oldest_r <= buf_r[wr_ptr_r];
        end
        ACCUM: begin
          sum_r           <= sum_next_s;
          buf_r[wr_ptr_r] <= sample_r;
          wr_ptr_r        <= wr_ptr_r + PTR_ONE;
          fill_r          <= fill_next_s;
        end
        default: begin
        end
      endcase
    end
  end

  // registered outputs; out_data only changes when a new average is presented
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data_r  <= 16'h0000;
      out_valid_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      out_valid_r <= (state_next_s == PRESENT);
      if ((state_r == ACCUM) && (state_next_s == PRESENT)) begin
        out_data_r <= avg_s;
      end
      if (discard_s) begin
        overrun_r <= 1'b1;
      end
    end
  end

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_adc_avg_filter.sv
// Bench for adc_avg_filter: window-average reference model feeding a scoreboard queue,
// checked by an independent monitor whenever the filter presents a result.
module tb_adc_avg_filter;

  localparam int D = 3;
  localparam int N = 1 << D;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sample_in = 16'h0000;
  logic        sample_strobe = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_valid;
  logic        overrun;

  int          chk_cnt = 0;
  int          pass_cnt = 0;
  logic [15:0] sb_q[$];
  int          win[$];
  bit          seen = 1'b0;
  bit          prev_hs = 1'b0;
  logic [15:0] held = 16'h0000;
  int          ready_mode = 1;
  bit          exp_ovr = 1'b0;

  adc_avg_filter #(.DEPTH_LOG2(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_strobe(sample_strobe),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // reference: average of the last N accepted samples, floored toward -inf
  task automatic model_accept(input logic [15:0] s);
    int sum;
    int q;
    win.push_back(int'($signed(s)));
    if (win.size() > N) void'(win.pop_front());
    if (win.size() == N) begin
      sum = 0;
      foreach (win[i]) sum += win[i];
      q = sum / N;
      if ((sum < 0) && ((sum % N) != 0)) q = q - 1;
      sb_q.push_back(16'(q));
    end
  endtask

  // out_ready driver: 0 = low, 1 = high, 2 = random
  always @(posedge clk) begin
    #2;
    if (ready_mode == 2) out_ready = ($urandom_range(0, 3) != 0);
    else out_ready = (ready_mode == 1);
  end

  // monitor: each new presentation pops one expectation; held data must not move
  always @(negedge clk) begin
    if (!rst) begin
      seen = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (prev_hs) seen = 1'b0;
      if (out_valid) begin
        if (!seen) begin
          if (sb_q.size() == 0) begin
            chk_cnt++;
            $display("FAIL unexpected_valid: got out_valid with data %0h, expected no output", out_data);
          end else begin
            held = sb_q.pop_front();
            chk("avg_out_data", out_data, held);
          end
          seen = 1'b1;
        end else begin
          chk("held_out_data", out_data, held);
        end
      end
      prev_hs = out_valid && out_ready;
    end
  end

  task automatic set_ready(input int mode);
    @(posedge clk); #1;
    ready_mode = mode;
  endtask

  task automatic do_reset();
    sample_strobe = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 16'h0000);
    chk("rst_overrun", overrun, 1'b0);
    win.delete();
    sb_q.delete();
    exp_ovr = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
  endtask

  task automatic send(input logic [15:0] s, input int hold, input bit acc, input bit wait_idle);
    int lim;
    if (acc) model_accept(s);
    @(posedge clk); #2 sample_in = s;
    @(posedge clk); #2 sample_strobe = 1'b1;
    lim = (hold > 7) ? hold : 7;
    for (int k = 1; k <= lim; k++) begin
      @(posedge clk); #2;
      if (k == hold) sample_strobe = 1'b0;
    end
    if (wait_idle) begin
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (!out_valid) break;
      end
      chk("idle_timeout", out_valid, 1'b0);
    end
  endtask

  // strobe whose window is full and out_ready is high: checks exact latency
  task automatic send_lat(input logic [15:0] s, input int hold);
    int lim;
    model_accept(s);
    @(posedge clk); #2 sample_in = s;
    @(posedge clk); #2 sample_strobe = 1'b1;
    lim = (hold > 7) ? hold : 7;
    for (int k = 1; k <= lim; k++) begin
      @(posedge clk); #1;
      if (k == 4) chk("lat_edge4_valid", out_valid, 1'b0);
      if (k == 5) chk("lat_edge5_valid", out_valid, 1'b1);
      if (k == 6) chk("lat_edge6_valid", out_valid, 1'b0);
      #1;
      if (k == hold) sample_strobe = 1'b0;
    end
  endtask

  initial begin
    #3;
    do_reset();

    // eight equal samples, only the eighth produces an output
    for (int i = 0; i < 7; i++) send(16'h4000, 1, 1'b1, 1'b1);
    send_lat(16'h4000, 1);
    send(16'hC000, 2, 1'b1, 1'b1);
    send_lat(16'h0800, 100);
    chk("no_overrun_yet", overrun, exp_ovr);

    // negative floor after reset
    do_reset();
    for (int i = 0; i < 7; i++) send(16'h0000, 1, 1'b1, 1'b1);
    send(16'hFFFF, 3, 1'b1, 1'b1);

    // backpressure: two strobes while held are dropped
    set_ready(0);
    send(16'h1000, 1, 1'b1, 1'b0);
    send(16'h7F00, 2, 1'b0, 1'b0);
    exp_ovr = 1'b1;
    send(16'h7F00, 4, 1'b0, 1'b0);
    chk("ovr_set", overrun, exp_ovr);
    chk("held_avg", out_data, 16'h01FF);
    chk("held_valid", out_valid, 1'b1);
    set_ready(1);
    @(posedge clk); #1;
    chk("valid_drop", out_valid, 1'b0);
    send(16'h0100, 1, 1'b1, 1'b1);
    chk("ovr_sticky", overrun, exp_ovr);

    // async reset mid-ACCUM
    @(posedge clk); #2 sample_in = 16'h5500;
    @(posedge clk); #2 sample_strobe = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    do_reset();

    // async reset mid-PRESENT, then a clean window
    for (int i = 0; i < 7; i++) send(16'h6000, 1, 1'b1, 1'b1);
    set_ready(0);
    send(16'h6000, 1, 1'b1, 1'b0);
    @(negedge clk); #2;
    chk("pre_reset_valid", out_valid, 1'b1);
    do_reset();
    set_ready(1);
    for (int i = 0; i < 8; i++) send(16'h2000, 1 + i % 3, 1'b1, 1'b1);

    // randomized samples, strobe widths and backpressure
    set_ready(2);
    for (int i = 0; i < 48; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      send({b, 8'h00}, $urandom_range(1, 5), 1'b1, 1'b1);
    end
    set_ready(1);
    repeat (20) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    chk("final_overrun", overrun, exp_ovr);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
